row_accumulator: RTL and testbench

Consumer-side counterpart of the value fetcher: drains the per-channel value FIFOs, sums each channel's entries into a per-row accumulator, and emits one completed row sum at a time over a valid/ready result port. It sits between the channel value FIFOs and the result writeback, pops each FIFO independently as data arrives, and shares a single output by round-robin arbitration.

---
 rtl/row_accumulator_pkg.sv | 17 +
 rtl/row_accumulator_rr_arbiter.sv | 32 +++
 rtl/row_accumulator.sv | 107 ++++++++++
 tb/tb_row_accumulator.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_accumulator_pkg.sv
// Shared sizing for the row accumulator and its round-robin arbiter.
// Entry layout: the top bit flags end-of-row, the remaining bits hold an unsigned value.
package row_accumulator_pkg;

  localparam int channel_num     = 8;
  localparam int channel_num_log = 3;
  localparam int val_bits        = 9;
  localparam int acc_bits        = 24;
  localparam int row_bits        = 16;
  localparam int eor_bit         = val_bits - 1;

  // Pointer advance that wraps at the last channel even if channel_num is not a power of two
  function automatic logic [channel_num_log-1:0] next_ptr(input logic [channel_num_log-1:0] idx);
    return (idx == channel_num_log'(channel_num - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/row_accumulator_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// Kept generic so the column path can reuse it.
module rr_arbiter #(
  parameter int n     = 8,
  parameter int n_log = 3
) (
  input  logic [n-1:0]     req,
  input  logic [n_log-1:0] ptr,
  output logic [n-1:0]     gnt,
  output logic [n_log-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < n; k++) begin
      cand = int'(ptr) + k;
      if (cand >= n) cand = cand - n;
      if (!any && req[n_log'(cand)]) begin
        any = 1'b1;
        idx = n_log'(cand);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/row_accumulator.sv
// Drains per-channel value FIFOs into per-row sums and emits completed rows
// one at a time through a round-robin-arbitrated valid/ready result register.
module row_accumulator
  import row_accumulator_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [channel_num-1:0]          empty,
  input  logic [val_bits*channel_num-1:0] in_data,
  output logic [channel_num-1:0]          read,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [acc_bits-1:0]             res_data,
  output logic [channel_num_log-1:0]      res_channel,
  output logic [row_bits-1:0]             res_row
);

  logic [channel_num-1:0]     pend;
  logic [channel_num-1:0]     pend_clr;
  logic [channel_num-1:0]     gnt;
  logic [channel_num_log-1:0] sel;
  logic [channel_num_log-1:0] rr;
  logic                       any_pend;
  logic                       free;
  logic [acc_bits-1:0]        rsum_arr [channel_num];
  logic [row_bits-1:0]        row_arr  [channel_num];

  for (genvar i = 0; i < channel_num; i++) begin : g_ch
    logic                vld;
    logic                pend_q;
    logic [acc_bits-1:0] acc;
    logic [acc_bits-1:0] rsum;
    logic [row_bits-1:0] row;
    logic [val_bits-1:0] entry;
    logic                eor;
    logic [acc_bits-1:0] val_ext;

    assign entry   = in_data[i*val_bits +: val_bits];
    assign eor     = entry[eor_bit];
    assign val_ext = acc_bits'(entry[val_bits-2:0]);

    // Stop fetching once an end-of-row entry is in hand: one finished row per channel in flight
    assign read[i] = ~rst & ~empty[i] & ~pend_q & ~(vld & eor);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld    <= 1'b0;
        pend_q <= 1'b0;
        acc    <= '0;
        rsum   <= '0;
        row    <= '0;
      end else begin
        vld <= read[i];
        if (pend_clr[i]) begin
          pend_q <= 1'b0;
          row    <= row + 1'b1;
        end
        if (vld) begin
          if (eor) begin
            rsum   <= acc + val_ext;
            pend_q <= 1'b1;
            acc    <= '0;
          end else begin
            acc <= acc + val_ext;
          end
        end
      end
    end

    assign pend[i]     = pend_q;
    assign rsum_arr[i] = rsum;
    assign row_arr[i]  = row;
  end

  rr_arbiter #(
    .n     (channel_num),
    .n_log (channel_num_log)
  ) u_arb (
    .req (pend),
    .ptr (rr),
    .gnt (gnt),
    .idx (sel),
    .any (any_pend)
  );

  assign free     = ~res_valid | res_ready;
  assign pend_clr = (free & any_pend) ? gnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_channel <= '0;
      res_row     <= '0;
      rr          <= '0;
    end else if (free) begin
      res_valid <= any_pend;
      if (any_pend) begin
        res_data    <= rsum_arr[sel];
        res_channel <= sel;
        res_row     <= row_arr[sel];
        rr          <= next_ptr(sel);
      end
    end
  end

endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: non-FWFT FIFO models per channel, a result
// logger on the handshake, and one task per scenario with hand-computed expectations.
module tb_row_accumulator;
  import row_accumulator_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic [channel_num-1:0]          empty;
  logic [val_bits*channel_num-1:0] in_data;
  logic [channel_num-1:0]          read;
  logic                            res_valid;
  logic                            res_ready = 1'b0;
  logic [acc_bits-1:0]             res_data;
  logic [channel_num_log-1:0]      res_channel;
  logic [row_bits-1:0]             res_row;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  row_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .empty       (empty),
    .in_data     (in_data),
    .read        (read),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_channel (res_channel),
    .res_row     (res_row)
  );

  // FIFO models: dout appears the cycle after read; reset flushes contents
  logic [8:0] fmem [8][256];
  int         wr_ptr [8];
  int         rd_ptr [8];
  logic [8:0] dout [8];

  for (genvar i = 0; i < 8; i++) begin : g_fifo
    assign empty[i]          = (wr_ptr[i] == rd_ptr[i]);
    assign in_data[i*9 +: 9] = dout[i];
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) begin
        rd_ptr[i] <= wr_ptr[i];
        dout[i]   <= '0;
      end else if (read[i]) begin
        dout[i]   <= fmem[i][8'(rd_ptr[i])];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt [8];
  int last_rd_cyc [8];
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (read[i]) begin
        rd_cnt[i]      = rd_cnt[i] + 1;
        last_rd_cyc[i] = cyc;
      end
    end
  end

  logic [23:0] log_data [512];
  logic [2:0]  log_ch   [512];
  logic [15:0] log_row  [512];
  int          log_cyc  [512];
  int          log_n = 0;
  int          log_rd = 0;

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      log_data[9'(log_n)] = res_data;
      log_ch[9'(log_n)]   = res_channel;
      log_row[9'(log_n)]  = res_row;
      log_cyc[9'(log_n)]  = cyc;
      log_n = log_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [8:0] v);
    fmem[ch][8'(wr_ptr[ch])] = v;
    wr_ptr[ch] = wr_ptr[ch] + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while ((log_n - log_rd) < n && k < budget) begin
      tick();
      k++;
    end
    ok = ((log_n - log_rd) >= n);
  endtask

  task automatic test_reset();
    tick();
    push(5, 9'h005);
    #1;
    vectors++;
    if (read !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_read: got %h expected 00", read);
    end
    vectors++;
    if ({res_valid, res_data, res_channel, res_row} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b data=%0d ch=%0d row=%0d expected all 0",
               res_valid, res_data, res_channel, res_row);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (read !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_flush_read: got %h expected 00", read);
    end
    repeat (4) tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_valid: got %0b expected 0", res_valid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int base;
    res_ready = 1'b1;
    log_rd = log_n;
    base = rd_cnt[0];
    push(0, 9'h003);
    push(0, 9'h005);
    push(0, 9'h107);
    wait_res(1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_timeout: got no result expected 1 result");
    end else begin
      vectors++;
      if (rd_cnt[0] - base !== 3) begin
        miscompares++;
        $display("FAIL basic_reads: got %0d expected 3", rd_cnt[0] - base);
      end
      vectors++;
      if (log_data[9'(log_rd)] !== 24'd15) begin
        miscompares++;
        $display("FAIL basic_data: got %0d expected 15", log_data[9'(log_rd)]);
      end
      vectors++;
      if (log_ch[9'(log_rd)] !== 3'd0 || log_row[9'(log_rd)] !== 16'd0) begin
        miscompares++;
        $display("FAIL basic_ch_row: got ch=%0d row=%0d expected ch=0 row=0",
                 log_ch[9'(log_rd)], log_row[9'(log_rd)]);
      end
      vectors++;
      if (log_cyc[9'(log_rd)] - last_rd_cyc[0] !== 3) begin
        miscompares++;
        $display("FAIL basic_latency: got %0d expected 3", log_cyc[9'(log_rd)] - last_rd_cyc[0]);
      end
      log_rd++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    res_ready = 1'b1;
    log_rd = log_n;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) push(i, 9'h100 | 9'(i + 1));
      wait_res(8, 30, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL b2b_timeout: got %0d results expected 8", log_n - log_rd);
      end else begin
        for (int k = 0; k < 8; k++) begin
          vectors++;
          if (log_data[9'(log_rd + k)] !== 24'(k + 1) || log_ch[9'(log_rd + k)] !== 3'(k)) begin
            miscompares++;
            $display("FAIL b2b_data: got data=%0d ch=%0d expected data=%0d ch=%0d",
                     log_data[9'(log_rd + k)], log_ch[9'(log_rd + k)], k + 1, k);
          end
          vectors++;
          if (log_row[9'(log_rd + k)] !== 16'(r)) begin
            miscompares++;
            $display("FAIL b2b_row: got %0d expected %0d", log_row[9'(log_rd + k)], r);
          end
          if (k > 0) begin
            vectors++;
            if (log_cyc[9'(log_rd + k)] - log_cyc[9'(log_rd + k - 1)] !== 1) begin
              miscompares++;
              $display("FAIL b2b_spacing: got %0d cycles expected 1",
                       log_cyc[9'(log_rd + k)] - log_cyc[9'(log_rd + k - 1)]);
            end
          end
        end
        log_rd += 8;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    do_reset();
    res_ready = 1'b0;
    log_rd = log_n;
    base = rd_cnt[2];
    push(2, 9'h004);
    push(2, 9'h104);
    push(2, 9'h001);
    push(2, 9'h101);
    repeat (6) tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if ({res_valid, res_data, res_channel} !== {1'b1, 24'd8, 3'd2}) begin
        miscompares++;
        $display("FAIL bp_hold: got valid=%0b data=%0d ch=%0d expected valid=1 data=8 ch=2",
                 res_valid, res_data, res_channel);
      end
    end
    vectors++;
    if (rd_cnt[2] - base !== 4) begin
      miscompares++;
      $display("FAIL bp_reads: got %0d expected 4", rd_cnt[2] - base);
    end
    tick();
    res_ready = 1'b1;
    wait_res(2, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_timeout: got %0d results expected 2", log_n - log_rd);
    end else begin
      vectors++;
      if (log_data[9'(log_rd)] !== 24'd8 || log_row[9'(log_rd)] !== 16'd0 || log_ch[9'(log_rd)] !== 3'd2) begin
        miscompares++;
        $display("FAIL bp_first: got data=%0d row=%0d ch=%0d expected data=8 row=0 ch=2",
                 log_data[9'(log_rd)], log_row[9'(log_rd)], log_ch[9'(log_rd)]);
      end
      vectors++;
      if (log_data[9'(log_rd + 1)] !== 24'd2 || log_row[9'(log_rd + 1)] !== 16'd1 || log_ch[9'(log_rd + 1)] !== 3'd2) begin
        miscompares++;
        $display("FAIL bp_second: got data=%0d row=%0d ch=%0d expected data=2 row=1 ch=2",
                 log_data[9'(log_rd + 1)], log_row[9'(log_rd + 1)], log_ch[9'(log_rd + 1)]);
      end
      log_rd += 2;
    end
  endtask

  task automatic test_empty_row();
    bit ok;
    res_ready = 1'b1;
    log_rd = log_n;
    push(6, 9'h100);
    wait_res(1, 20, ok);
    vectors++;
    if (!ok || log_data[9'(log_rd)] !== 24'd0 || log_ch[9'(log_rd)] !== 3'd6) begin
      miscompares++;
      $display("FAIL empty_row: got ok=%0b data=%0d ch=%0d expected ok=1 data=0 ch=6",
               ok, log_data[9'(log_rd)], log_ch[9'(log_rd)]);
    end
    if (ok) log_rd++;
    push(6, 9'h00A);
    repeat (3) tick();
    push(6, 9'h014);
    repeat (2) tick();
    push(6, 9'h11E);
    wait_res(1, 20, ok);
    vectors++;
    if (!ok || log_data[9'(log_rd)] !== 24'd60 || log_row[9'(log_rd)] !== 16'd1) begin
      miscompares++;
      $display("FAIL gappy_row: got ok=%0b data=%0d row=%0d expected ok=1 data=60 row=1",
               ok, log_data[9'(log_rd)], log_row[9'(log_rd)]);
    end
    if (ok) log_rd++;
  endtask

  task automatic test_wrap();
    bit ok;
    res_ready = 1'b1;
    log_rd = log_n;
    // 65794 entries of 255 sum to 16777470, which is 254 modulo 2^24
    for (int n = 0; n < 65793; n++) begin
      push(3, 9'h0FF);
      tick();
    end
    push(3, 9'h1FF);
    wait_res(1, 20, ok);
    vectors++;
    if (!ok || log_data[9'(log_rd)] !== 24'd254 || log_ch[9'(log_rd)] !== 3'd3) begin
      miscompares++;
      $display("FAIL wrap_sum: got ok=%0b data=%0d ch=%0d expected ok=1 data=254 ch=3",
               ok, log_data[9'(log_rd)], log_ch[9'(log_rd)]);
    end
    if (ok) log_rd++;
    push(3, 9'h105);
    wait_res(1, 20, ok);
    vectors++;
    if (!ok || log_data[9'(log_rd)] !== 24'd5) begin
      miscompares++;
      $display("FAIL wrap_next_row: got ok=%0b data=%0d expected ok=1 data=5",
               ok, log_data[9'(log_rd)]);
    end
    if (ok) log_rd++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    res_ready = 1'b0;
    log_rd = log_n;
    push(4, 9'h101);
    push(4, 9'h102);
    push(1, 9'h007);
    push(1, 9'h008);
    repeat (8) tick();
    vectors++;
    if (res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre_valid: got %0b expected 1", res_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({res_valid, res_data, res_channel, res_row} !== '0 || read !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_async_clear: got valid=%0b data=%0d ch=%0d row=%0d read=%h expected all 0",
               res_valid, res_data, res_channel, res_row, read);
    end
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    push(1, 9'h103);
    push(4, 9'h102);
    wait_res(2, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL mid_timeout: got %0d results expected 2", log_n - log_rd);
    end else begin
      vectors++;
      if (log_data[9'(log_rd)] !== 24'd3 || log_ch[9'(log_rd)] !== 3'd1 || log_row[9'(log_rd)] !== 16'd0) begin
        miscompares++;
        $display("FAIL mid_ch1: got data=%0d ch=%0d row=%0d expected data=3 ch=1 row=0",
                 log_data[9'(log_rd)], log_ch[9'(log_rd)], log_row[9'(log_rd)]);
      end
      vectors++;
      if (log_data[9'(log_rd + 1)] !== 24'd2 || log_ch[9'(log_rd + 1)] !== 3'd4 || log_row[9'(log_rd + 1)] !== 16'd0) begin
        miscompares++;
        $display("FAIL mid_ch4: got data=%0d ch=%0d row=%0d expected data=2 ch=4 row=0",
                 log_data[9'(log_rd + 1)], log_ch[9'(log_rd + 1)], log_row[9'(log_rd + 1)]);
      end
      log_rd += 2;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_empty_row();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
